lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the MEM stage of the RISC-V pipeline. It sits between the EX/MEM pipeline register and the word-only synchronous data memory (1-cycle read latency, 32-bit write, word index from addr[9:2]). It turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sub-word stores use a read-modify-write sequence. Loads are aligned and sign- or zero-extended, and misaligned or illegal accesses are reported to the hazard/trap logic.

## Interface
Parameters:
- ADDR_W, 32, width of address bus
- MEM_IDX_HI, 9, top address bit used by the memory (word index = addr[MEM_IDX_HI:2])

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  EX/MEM holds a memory instruction
- req_read  in  1  load request
- req_write  in  1  store request
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold EX/MEM and earlier stages this cycle
- MemRead  out  1  to data memory
- MemWrite  out  1  to data memory
- mem_addr  out  ADDR_W  to data memory, always word-aligned ([1:0]=0)
- mem_wdata  out  32  to data memory
- mem_rdata  in  32  from data memory, valid the cycle after MemRead
- load_valid  out  1  one-cycle pulse, load_data valid
- load_data  out  32  aligned, extended load result
- err_valid  out  1  one-cycle pulse, access rejected
- err_cause  out  2  01 misaligned load, 10 misaligned store, 11 illegal request
- err_addr  out  ADDR_W  offending byte address

## Operation
- FSM states: IDLE, LOAD_WAIT, RMW_WRITE.
- Requests are accepted only in IDLE with req_valid=1.
- Illegal request: req_read and req_write both 1, or funct3 in {3,6,7} for a load, or funct3 in {3..7} for a store.
  - No memory access.
  - err_valid=1 with cause 11 next cycle.
  - Stays in IDLE.
- Misalignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - A violation causes no memory access; err_valid pulses next cycle with cause 01 or 10 and err_addr = req_addr.
- SW (aligned): MemWrite=1, mem_wdata = req_wdata, in the accept cycle. Stays in IDLE. No stall.
- Load (aligned): MemRead=1 in the accept cycle, stall=1, go to LOAD_WAIT. Latch funct3 and addr[1:0].
- LOAD_WAIT:
  - Select byte/half from mem_rdata using the latched addr[1:0] (little-endian).
  - Extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - Register the result into load_data and pulse load_valid. Return to IDLE. stall=0.
- SB/SH (aligned):
  - Accept cycle: MemRead=1, stall=1, go to RMW_WRITE. Latch addr, data and size.
  - RMW_WRITE: merge the latched byte/half into mem_rdata at lane addr[1:0] and issue MemWrite=1 with the merged word. Return to IDLE. stall=0.
- mem_addr = {addr[ADDR_W-1:2], 2'b00}, taken from req_addr in IDLE and from the latched address in the other states.
- MemRead and MemWrite are never both 1. Neither is 1 when req_valid=0 in IDLE.

## Timing
- Reset values (asynchronous): state=IDLE, load_valid=0, load_data=0, err_valid=0, err_cause=0, err_addr=0, all latches 0.
- Combinational outputs under reset: stall=0, MemRead=0, MemWrite=0.
- Load accepted in cycle N: stall high in N only; load_valid/load_data in N+2.
- Sub-word store accepted in N: read in N, write in N+1; stall high in N only.
- SW: write in N, 0 stall cycles. Error: err_valid in N+1, 0 stall cycles.
- Back-to-back: a new request can be accepted in N+2 after a 2-cycle op, or in N+1 after SW or an error.
- Reset asserted mid-operation: FSM returns to IDLE immediately. A pending RMW write is dropped (MemWrite deasserts asynchronously). No load_valid or err_valid is produced.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: misalignment is detected and reported as above.
- Undefined: misalignment is not checked.
  - addr[0] is forced to 0 for halfwords; addr[1:0] is forced to 0 for words.
  - The access proceeds normally.
  - err_cause 01/10 never occurs; illegal-request detection (11) remains.

## Test plan
- Reset then SW addr=0x10 data=0xDEADBEEF → MemWrite=1 same cycle, mem_addr=0x10, stall=0; then LW 0x10 → load_data=0xDEADBEEF two cycles later, load_valid one cycle.
- Word 0x80FF7F01 at 0x20: LB 0x20→0x00000001, LB 0x21→0x0000007F, LB 0x22→0xFFFFFFFF, LBU 0x23→0x00000080, LH 0x22→0xFFFF80FF, LHU 0x22→0x000080FF.
- Word 0x11223344 at 0x30, SB 0x31 data=0xAA → read then write 0x1122AA44; SH 0x32 data=0xBEEF → 0xBEEFAA44; stall high exactly one cycle each.
- With LSU_MISALIGN_CHECK_EN: LW 0x42 → err_valid, cause 01, err_addr 0x42, no MemRead; SH 0x43 → cause 10, no MemWrite. Without it: LW 0x42 reads word 0x40.
- req_read=req_write=1 → cause 11, no memory access; load funct3=7 → cause 11.
- Assert rst_n=0 in RMW_WRITE cycle of SB → MemWrite=0, memory unchanged, state IDLE, no load_valid/err_valid after release.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: turns RV32I loads/stores into word accesses on a 1-cycle synchronous RAM.
// Optional LSU_MISALIGN_CHECK_EN reports misaligned accesses; otherwise low address bits are forced to size alignment.
module lsu_mem_stage #(
  parameter int ADDR_W     = 32,
  parameter int MEM_IDX_HI = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              err_valid,
  output logic [1:0]        err_cause,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;

  logic              accept, is_ld, is_st, illegal, misalign, go, err;
  logic [ADDR_W-1:0] ea;
  logic [31:0]       merged, shifted, load_ext;

  // Request decode: legality, alignment and effective (size-aligned) address.
  always_comb begin
    is_ld    = req_read & ~req_write;
    is_st    = req_write & ~req_read;
    illegal  = (req_read & req_write)
             | (is_ld & ((req_funct3[1:0] == 2'b11) | (req_funct3 == 3'd6)))
             | (is_st & (req_funct3[2] | (req_funct3[1:0] == 2'b11)));
    ea       = req_addr;
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01: begin
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = req_addr[0];
`endif
        ea[0] = 1'b0;
      end
      2'b10: begin
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = |req_addr[1:0];
`endif
        ea[1:0] = 2'b00;
      end
      default: ;
    endcase
    accept = rst_n & req_valid & (state_q == IDLE);
    go     = accept & (is_ld | is_st) & ~illegal & ~misalign;
    err    = accept & (illegal | ((is_ld | is_st) & misalign));
  end

  // Store-lane merge and load-lane extraction (little-endian).
  always_comb begin
    merged = mem_rdata;
    if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_ext = {24'h000000, shifted[7:0]};
      3'd5:    load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata = merged;
    case (state_q)
      IDLE: begin
        // Word index bits split out so the memory's addressed range is explicit.
        mem_addr  = {req_addr[ADDR_W-1:MEM_IDX_HI+1], req_addr[MEM_IDX_HI:2], 2'b00};
        mem_wdata = req_wdata;
        if (go) begin
          if (is_st && (req_funct3[1:0] == 2'b10)) begin
            MemWrite = 1'b1;
          end else begin
            MemRead = 1'b1;
            stall   = 1'b1;
            state_d = is_ld ? LOAD_WAIT : RMW_WRITE;
          end
        end
      end
      LOAD_WAIT: state_d = IDLE;
      RMW_WRITE: begin
        MemWrite = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      err_valid  <= 1'b0;
      err_cause  <= '0;
      err_addr   <= '0;
    end else begin
      state_q    <= state_d;
      load_valid <= (state_q == LOAD_WAIT);
      err_valid  <= err;
      if (go) begin
        f3_q    <= req_funct3;
        addr_q  <= ea;
        wdata_q <= req_wdata[15:0];
      end
      if (state_q == LOAD_WAIT) load_data <= load_ext;
      if (err) begin
        err_cause <= illegal ? 2'b11 : (is_ld ? 2'b01 : 2'b10);
        err_addr  <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed test-plan scenarios plus randomized requests
// checked against a byte-level reference memory model.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_read, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, MemRead, MemWrite;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        load_valid;
  logic [31:0] load_data;
  logic        err_valid;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] envmem  [256];
  logic [31:0] ref_mem [256];

  lsu_mem_stage #(.ADDR_W(32), .MEM_IDX_HI(9)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .load_valid(load_valid), .load_data(load_data), .err_valid(err_valid),
    .err_cause(err_cause), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Synchronous data memory seen by the DUT.
  always @(posedge clk) begin
    if (MemWrite) envmem[mem_addr[9:2]] <= mem_wdata;
    if (MemRead)  mem_rdata <= envmem[mem_addr[9:2]];
  end

  function automatic int sz_of(input logic isld, input logic [2:0] f3);
    if (isld) begin
      case (f3)
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    end else begin
      case (f3)
        3'd0:    return 1;
        3'd1:    return 2;
        3'd2:    return 4;
        default: return 0;
      endcase
    end
  endfunction

  // kind: 0 no-op, 1 error, 2 SW, 3 load, 4 sub-word store
  task automatic op(input logic r, input logic w, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d, input bit b2b);
    int size, kind;
    logic [1:0] ecause;
    logic [31:0] ea, eword, eld;
    logic [7:0] idx;
    longint unsigned v;
    size = (r & w) ? 0 : sz_of(r, f3);
    ea = a; kind = 0; ecause = 2'b00; eword = '0; eld = '0;
    if (!r && !w) kind = 0;
    else if (size == 0) begin kind = 1; ecause = 2'b11; end
    else begin
`ifdef LSU_MISALIGN_CHECK_EN
      if ((a % size) != 0) begin kind = 1; ecause = r ? 2'b01 : 2'b10; end
      else kind = r ? 3 : (size == 4 ? 2 : 4);
`else
      ea = a - (a % size);
      kind = r ? 3 : (size == 4 ? 2 : 4);
`endif
    end
    idx = ea[9:2];
    if (kind == 3) begin
      v = (longint'(ref_mem[idx]) >> (8 * ea[1:0])) & ((64'd1 << (8 * size)) - 1);
      if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1)))
        v = v + 64'h1_0000_0000 - (64'd1 << (8 * size));
      eld = v[31:0];
    end
    if (kind == 2) ref_mem[idx] = d;
    if (kind == 4) begin
      eword = ref_mem[idx];
      for (int b = 0; b < size; b++) eword[(ea[1:0] + b) * 8 +: 8] = d[b * 8 +: 8];
      ref_mem[idx] = eword;
    end

    req_valid = 1'b1; req_read = r; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    #1;
    vectors++;
    if ({stall, MemRead, MemWrite} !== ((kind == 2) ? 3'b001 : (kind >= 3) ? 3'b110 : 3'b000)) begin
      errors++;
      $display("FAIL accept_ctl a=%h f3=%0d kind=%0d: stall/rd/wr got %b", a, f3, kind, {stall, MemRead, MemWrite});
    end
    if (kind >= 2) begin
      vectors++;
      if (mem_addr !== {ea[31:2], 2'b00}) begin
        errors++; $display("FAIL accept_addr got %h want %h", mem_addr, {ea[31:2], 2'b00});
      end
    end
    if (kind == 2) begin
      vectors++;
      if (mem_wdata !== d) begin errors++; $display("FAIL sw_wdata got %h want %h", mem_wdata, d); end
    end

    @(negedge clk);
    if (kind < 3 && !b2b) req_valid = 1'b0;
    #1;
    vectors++;
    if (err_valid !== (kind == 1)) begin
      errors++; $display("FAIL err_valid a=%h got %b want %b", a, err_valid, kind == 1);
    end
    if (kind == 1) begin
      vectors++;
      if ({err_cause, err_addr} !== {ecause, a}) begin
        errors++; $display("FAIL err_info got %b/%h want %b/%h", err_cause, err_addr, ecause, a);
      end
    end
    if (kind == 3) begin
      vectors++;
      if ({stall, MemRead, MemWrite, load_valid} !== 4'b0000) begin
        errors++; $display("FAIL load_wait got %b want 0000", {stall, MemRead, MemWrite, load_valid});
      end
    end
    if (kind == 4) begin
      vectors++;
      if ({stall, MemRead, MemWrite, mem_addr, mem_wdata} !== {3'b001, ea[31:2], 2'b00, eword}) begin
        errors++;
        $display("FAIL rmw_write ctl=%b addr=%h data=%h want 001 %h %h",
                 {stall, MemRead, MemWrite}, mem_addr, mem_wdata, {ea[31:2], 2'b00}, eword);
      end
    end

    if (kind >= 3) begin
      @(negedge clk);
      if (!b2b) req_valid = 1'b0;
      #1;
      if (kind == 3) begin
        vectors++;
        if ({load_valid, load_data} !== {1'b1, eld}) begin
          errors++; $display("FAIL load_result a=%h f3=%0d got %b/%h want 1/%h", a, f3, load_valid, load_data, eld);
        end
      end
    end

    if (!b2b) begin
      @(negedge clk); #1;
      vectors++;
      if ({load_valid, err_valid} !== 2'b00) begin
        errors++; $display("FAIL pulse_width got %b want 00", {load_valid, err_valid});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = '0;
    #3;
    vectors++;
    if ({stall, MemRead, MemWrite, load_valid, load_data, err_valid, err_cause, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state got ctl=%b lv=%b ld=%h ev=%b ec=%b ea=%h want all zero",
               {stall, MemRead, MemWrite}, load_valid, load_data, err_valid, err_cause, err_addr);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    #1;
  endtask

  task automatic test_sw_lw();
    op(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    op(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
  endtask

  task automatic test_load_ext();
    op(1'b0, 1'b1, 3'd2, 32'h20, 32'h80FF7F01, 1'b0);
    op(1'b1, 1'b0, 3'd0, 32'h20, 32'h0, 1'b0);
    op(1'b1, 1'b0, 3'd0, 32'h21, 32'h0, 1'b0);
    op(1'b1, 1'b0, 3'd0, 32'h22, 32'h0, 1'b0);
    op(1'b1, 1'b0, 3'd4, 32'h23, 32'h0, 1'b0);
    op(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, 1'b0);
    op(1'b1, 1'b0, 3'd5, 32'h22, 32'h0, 1'b0);
  endtask

  task automatic test_subword_store();
    op(1'b0, 1'b1, 3'd2, 32'h30, 32'h11223344, 1'b0);
    op(1'b0, 1'b1, 3'd0, 32'h31, 32'h000000AA, 1'b0);
    op(1'b0, 1'b1, 3'd1, 32'h32, 32'h0000BEEF, 1'b0);
    vectors++;
    if (envmem[12] !== 32'hBEEFAA44) begin
      errors++; $display("FAIL rmw_memory got %h want beefaa44", envmem[12]);
    end
    op(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
  endtask

  task automatic test_misalign();
    op(1'b0, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 1'b0);
    op(1'b1, 1'b0, 3'd2, 32'h42, 32'h0, 1'b0);
    op(1'b0, 1'b1, 3'd1, 32'h43, 32'h00001234, 1'b0);
    op(1'b1, 1'b0, 3'd5, 32'h41, 32'h0, 1'b0);
    op(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
  endtask

  task automatic test_illegal();
    op(1'b1, 1'b1, 3'd2, 32'h10, 32'h0, 1'b0);
    op(1'b1, 1'b0, 3'd7, 32'h10, 32'h0, 1'b0);
    op(1'b1, 1'b0, 3'd6, 32'h14, 32'h0, 1'b0);
    op(1'b0, 1'b1, 3'd3, 32'h18, 32'h55, 1'b0);
    op(1'b0, 1'b1, 3'd4, 32'h1C, 32'h55, 1'b0);
  endtask

  task automatic test_back_to_back();
    op(1'b0, 1'b1, 3'd2, 32'h60, 32'hA5A5_5A5A, 1'b1);
    op(1'b1, 1'b0, 3'd2, 32'h60, 32'h0, 1'b1);
    op(1'b0, 1'b1, 3'd0, 32'h62, 32'h0000_0077, 1'b1);
    op(1'b1, 1'b1, 3'd0, 32'h60, 32'h0, 1'b1);
    op(1'b1, 1'b0, 3'd1, 32'h62, 32'h0, 1'b1);
    op(1'b0, 1'b1, 3'd2, 32'h64, 32'h0BAD_F00D, 1'b1);
    op(1'b1, 1'b0, 3'd4, 32'h62, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_rmw();
    op(1'b0, 1'b1, 3'd2, 32'h50, 32'h11223344, 1'b0);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h51; req_wdata = 32'h55;
    #1;
    vectors++;
    if ({stall, MemRead, MemWrite} !== 3'b110) begin
      errors++; $display("FAIL midrst_accept got %b want 110", {stall, MemRead, MemWrite});
    end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({stall, MemRead, MemWrite} !== 3'b000) begin
      errors++; $display("FAIL midrst_drop got %b want 000", {stall, MemRead, MemWrite});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({envmem[20], load_valid, err_valid, load_data} !== {32'h11223344, 2'b00, 32'h0}) begin
      errors++;
      $display("FAIL midrst_after mem=%h lv=%b ev=%b ld=%h want 11223344 0 0 0",
               envmem[20], load_valid, err_valid, load_data);
    end
    @(negedge clk); #1;
    vectors++;
    if ({load_valid, err_valid, MemWrite} !== 3'b000) begin
      errors++; $display("FAIL midrst_idle got %b want 000", {load_valid, err_valid, MemWrite});
    end
    op(1'b1, 1'b0, 3'd2, 32'h50, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic r, w;
    logic [2:0] f3;
    int k;
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      r = (k == 0) || (k >= 2 && k <= 5);
      w = (k == 0) || (k >= 6);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) f3 = (r && $urandom_range(0, 1) == 1) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2));
      op(r, w, f3, 32'($urandom_range(0, 32'h3FF)), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      envmem[i] = '0;
      ref_mem[i] = '0;
    end
    mem_rdata = '0;
    test_reset();
    test_sw_lw();
    test_load_ext();
    test_subword_store();
    test_misalign();
    test_illegal();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
